// File: rtl/mem_request_queue_if.sv
// Bundle between the request queue, its requesting cores and the single-port data RAM.
interface mem_request_queue_if #(
  parameter int unsigned port_count = 2,
  parameter int unsigned addr_width = 12,
  parameter int unsigned mem_width  = 12
);
  logic [port_count-1:0]            req;
  logic [port_count-1:0]            wr;
  logic [addr_width*port_count-1:0] address;
  logic [mem_width*port_count-1:0]  datain;
  logic [mem_width*port_count-1:0]  dataout;
  logic [port_count-1:0]            done;
  logic                             busy;
  logic [addr_width-1:0]            mem_addr;
  logic [mem_width-1:0]             mem_wdata;
  logic                             mem_wren;
  logic [mem_width-1:0]             mem_rdata;

  // Everything outside the queue (cores and RAM) drives through master.
  modport master (
    output req, wr, address, datain, mem_rdata,
    input  dataout, done, busy, mem_addr, mem_wdata, mem_wren
  );

  modport slave (
    input  req, wr, address, datain, mem_rdata,
    output dataout, done, busy, mem_addr, mem_wdata, mem_wren
  );
endinterface

// File: rtl/mem_request_queue.sv
// Round-robin arbiter serialising per-core requests onto one single-port RAM;
// fixed three-cycle access: IDLE (grant) -> ACCESS (RAM cycle) -> CAPTURE (read data).
module mem_request_queue #(
  parameter int unsigned port_count = 2,
  parameter int unsigned addr_width = 12,
  parameter int unsigned mem_width  = 12
) (
  input logic                 clk,
  input logic                 reset,
  mem_request_queue_if.slave  bus
);
  localparam int unsigned idx_w = (port_count > 1) ? $clog2(port_count) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE} state_t;

  state_t                 state;
  logic [idx_w-1:0]       rr_ptr;
  logic [idx_w-1:0]       sel;
  logic                   sel_wr;
  logic [port_count-1:0]  eligible;
  logic                   any_elig;
  logic [idx_w-1:0]       grant_idx;
  logic [idx_w-1:0]       cand;

  // A port whose done pulse is showing cannot be re-granted in that same cycle.
  always_comb eligible = bus.req & ~bus.done;

  // First eligible port at or above rr_ptr, wrapping.
  always_comb begin
    any_elig  = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned i = 0; i < port_count; i++) begin
      cand = idx_w'((32'(rr_ptr) + i) % port_count);
      if (!any_elig && eligible[cand]) begin
        any_elig  = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      sel           <= '0;
      sel_wr        <= 1'b0;
      bus.done      <= '0;
      bus.busy      <= 1'b0;
      bus.mem_wren  <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.dataout   <= '0;
    end else begin
      bus.done <= '0;
      case (state)
        IDLE: begin
          if (any_elig) begin
            state         <= ACCESS;
            bus.busy      <= 1'b1;
            sel           <= grant_idx;
            sel_wr        <= bus.wr[grant_idx];
            bus.mem_wren  <= bus.wr[grant_idx];
            bus.mem_addr  <= bus.address[32'(grant_idx)*addr_width +: addr_width];
            bus.mem_wdata <= bus.datain[32'(grant_idx)*mem_width +: mem_width];
            rr_ptr        <= idx_w'((32'(grant_idx) + 1) % port_count);
          end
        end
        ACCESS: begin
          state        <= CAPTURE;
          bus.mem_wren <= 1'b0;
        end
        CAPTURE: begin
          state         <= IDLE;
          bus.busy      <= 1'b0;
          bus.done[sel] <= 1'b1;
          if (!sel_wr) begin
            bus.dataout[32'(sel)*mem_width +: mem_width] <= bus.mem_rdata;
          end
        end
        default: begin
          state        <= IDLE;
          bus.busy     <= 1'b0;
          bus.mem_wren <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_request_queue.sv
// Bench for mem_request_queue: table of single accesses plus hand-written
// contention, done-masking, reset-abort and late-input-change sequences.
module tb_mem_request_queue;
  localparam int unsigned PC = 2;
  localparam int unsigned AW = 12;
  localparam int unsigned MW = 12;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_request_queue_if #(.port_count(PC), .addr_width(AW), .mem_width(MW)) bif ();

  mem_request_queue #(.port_count(PC), .addr_width(AW), .mem_width(MW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  // Single-port RAM with one-cycle registered read, plus a preload port.
  logic [MW-1:0] ram [0:(1<<AW)-1];
  logic          pre_we;
  logic [AW-1:0] pre_addr;
  logic [MW-1:0] pre_data;

  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (bif.mem_wren) ram[bif.mem_addr] <= bif.mem_wdata;
    bif.mem_rdata <= ram[bif.mem_addr];
  end

  typedef struct {
    int unsigned port;
    logic        wr;
    logic [MW-1:0] rdata;
  } exp_t;

  typedef struct {
    int unsigned   port;
    logic          wr;
    logic [AW-1:0] addr;
    logic [MW-1:0] data;
    logic [MW-1:0] rdata;
  } vec_t;

  exp_t              sbq[$];
  vec_t              vecs[8];
  logic [MW*PC-1:0]  exp_dout;
  int                checks = 0;
  int                errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int unsigned p, input logic w, input logic [MW-1:0] d);
    exp_t e;
    e.port  = p;
    e.wr    = w;
    e.rdata = d;
    sbq.push_back(e);
  endtask

  // Advance to the next falling edge; any done pulse is matched against the scoreboard.
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (bif.done != '0) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done=%b with nothing pending", bif.done);
      end else begin
        e = sbq.pop_front();
        check("done_port", 32'(bif.done), 32'(1) << e.port);
        if (!e.wr) exp_dout[e.port*MW +: MW] = e.rdata;
        check("dataout", 32'(bif.dataout), 32'(exp_dout));
      end
    end
  endtask

  task automatic drive(input int unsigned p, input logic w, input logic [AW-1:0] a,
                       input logic [MW-1:0] d);
    bif.wr[p]              = w;
    bif.address[p*AW +: AW] = a;
    bif.datain[p*MW +: MW]  = d;
    bif.req[p]             = 1'b1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [MW-1:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    @(negedge clk);
    pre_we   = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_done"},  32'(bif.done), 32'(0));
    check({tag, "_busy"},  32'(bif.busy), 32'(0));
    check({tag, "_wren"},  32'(bif.mem_wren), 32'(0));
    check({tag, "_addr"},  32'(bif.mem_addr), 32'(0));
    check({tag, "_wdata"}, 32'(bif.mem_wdata), 32'(0));
    check({tag, "_dout"},  32'(bif.dataout), 32'(0));
  endtask

  task automatic apply_reset();
    reset   = 1'b1;
    bif.req = '0;
    step();
    step();
    exp_dout = '0;
    reset    = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    pre_we        = 1'b0;
    pre_addr      = '0;
    pre_data      = '0;
    bif.req       = '0;
    bif.wr        = '0;
    bif.address   = '0;
    bif.datain    = '0;
    exp_dout      = '0;

    vecs[0] = '{0, 1'b0, 12'h010, 12'h000, 12'h0AB};
    vecs[1] = '{1, 1'b1, 12'h020, 12'h5A5, 12'h000};
    vecs[2] = '{0, 1'b0, 12'h020, 12'h000, 12'h5A5};
    vecs[3] = '{1, 1'b0, 12'h010, 12'h000, 12'h0AB};
    vecs[4] = '{0, 1'b1, 12'hFFF, 12'h123, 12'h000};
    vecs[5] = '{1, 1'b0, 12'hFFF, 12'h000, 12'h123};
    vecs[6] = '{0, 1'b1, 12'h000, 12'hFFF, 12'h000};
    vecs[7] = '{0, 1'b0, 12'h000, 12'h000, 12'hFFF};

    @(negedge clk);
    preload(12'h010, 12'h0AB);
    preload(12'h040, 12'h111);
    preload(12'h041, 12'h222);
    apply_reset();
    check_all_zero("reset");

    // Single accesses, one at a time.
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].port, vecs[i].wr, vecs[i].addr, vecs[i].data);
      push_exp(vecs[i].port, vecs[i].wr, vecs[i].rdata);
      step();
      check("acc_busy", 32'(bif.busy), 32'(1));
      check("acc_addr", 32'(bif.mem_addr), 32'(vecs[i].addr));
      check("acc_wren", 32'(bif.mem_wren), 32'(vecs[i].wr));
      if (vecs[i].wr) check("acc_wdata", 32'(bif.mem_wdata), 32'(vecs[i].data));
      step();
      check("cap_wren", 32'(bif.mem_wren), 32'(0));
      check("cap_busy", 32'(bif.busy), 32'(1));
      step();
      check("vec_drained", 32'(sbq.size()), 32'(0));
      check("done_busy", 32'(bif.busy), 32'(0));
      bif.req = '0;
      step();
      check("post_done", 32'(bif.done), 32'(0));
    end

    // Both ports requesting from reset: rotate 0,1,0,1 every three cycles.
    apply_reset();
    drive(0, 1'b0, 12'h010, 12'h000);
    drive(1, 1'b0, 12'h020, 12'h000);
    push_exp(0, 1'b0, 12'h0AB);
    push_exp(1, 1'b0, 12'h5A5);
    push_exp(0, 1'b0, 12'h0AB);
    push_exp(1, 1'b0, 12'h5A5);
    for (int s = 1; s <= 12; s++) begin
      step();
      if (s % 3 == 0) check("rr_pending", 32'(sbq.size()), 32'(4 - s / 3));
      else check("rr_no_done", 32'(bif.done), 32'(0));
    end
    bif.req = '0;
    step();
    check("rr_quiet", 32'(bif.done), 32'(0));

    // req[0] held through its done cycle: no grant there, re-grant one cycle later.
    drive(0, 1'b0, 12'h020, 12'h000);
    push_exp(0, 1'b0, 12'h5A5);
    push_exp(0, 1'b0, 12'h5A5);
    step();
    step();
    step();
    check("mask_drain1", 32'(sbq.size()), 32'(1));
    check("mask_busy_done", 32'(bif.busy), 32'(0));
    step();
    check("mask_idle_busy", 32'(bif.busy), 32'(0));
    check("mask_idle_done", 32'(bif.done), 32'(0));
    step();
    check("mask_regrant", 32'(bif.busy), 32'(1));
    check("mask_addr", 32'(bif.mem_addr), 32'(12'h020));
    step();
    step();
    check("mask_drain2", 32'(sbq.size()), 32'(0));
    bif.req = '0;
    step();

    // Reset during a write's ACCESS cycle aborts it; held req re-arbitrates.
    drive(1, 1'b1, 12'h030, 12'h777);
    step();
    check("abort_wren_on", 32'(bif.mem_wren), 32'(1));
    reset = 1'b1;
    step();
    check_all_zero("abort");
    exp_dout = '0;
    reset    = 1'b0;
    push_exp(1, 1'b1, 12'h000);
    step();
    check("rearb_busy", 32'(bif.busy), 32'(1));
    check("rearb_wren", 32'(bif.mem_wren), 32'(1));
    check("rearb_addr", 32'(bif.mem_addr), 32'(12'h030));
    check("rearb_wdata", 32'(bif.mem_wdata), 32'(12'h777));
    step();
    step();
    check("rearb_drained", 32'(sbq.size()), 32'(0));
    bif.req = '0;
    step();

    // Address change after grant must not reach the RAM.
    drive(0, 1'b0, 12'h040, 12'h000);
    push_exp(0, 1'b0, 12'h111);
    step();
    check("late_addr_acc", 32'(bif.mem_addr), 32'(12'h040));
    bif.address[0 +: AW] = 12'h041;
    step();
    check("late_addr_cap", 32'(bif.mem_addr), 32'(12'h040));
    step();
    check("late_drained", 32'(sbq.size()), 32'(0));
    bif.req = '0;
    step();
    step();

    check("final_queue", 32'(sbq.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_request_queue.md
MEM_REQUEST_QUEUE -- requirements
Module: mem_request_queue

Interface
REQ-001 The module SHALL have parameter port_count, default 2, giving the number of core request ports.
REQ-002 The module SHALL have parameter addr_width, default 12, giving the data-memory address width.
REQ-003 The module SHALL have parameter mem_width, default 12, giving the data word width.
REQ-004 The module SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 The module SHALL have port req, input, port_count, per-core access request, level-held until that core's done.
REQ-007 The module SHALL have port wr, input, port_count, per-core write flag (1=write, 0=read), valid while req high.
REQ-008 The module SHALL have port address, input, addr_width*port_count, flattened; port j uses bits [(j+1)*addr_width-1 -: addr_width].
REQ-009 The module SHALL have port datain, input, mem_width*port_count, flattened per-core write data, same slicing as address.
REQ-010 The module SHALL have port dataout, output, mem_width*port_count, flattened per-core read data hold registers.
REQ-011 The module SHALL have port done, output, port_count, one-cycle completion pulse per core.
REQ-012 The module SHALL have port busy, output, 1, high whenever the FSM is not IDLE.
REQ-013 The module SHALL have port mem_addr, output, addr_width, address to the single-port data RAM.
REQ-014 The module SHALL have port mem_wdata, output, mem_width, write data to the RAM.
REQ-015 The module SHALL have port mem_wren, output, 1, RAM write enable.
REQ-016 The module SHALL have port mem_rdata, input, mem_width, RAM read data, valid one cycle after mem_addr is presented.

Function
REQ-017 The FSM SHALL have states IDLE, ACCESS, CAPTURE; IDLE->ACCESS when any eligible req; ACCESS->CAPTURE unconditionally; CAPTURE->IDLE unconditionally.
REQ-018 In IDLE, a port SHALL be eligible when req[j]=1 and done[j]=0 in that cycle.
REQ-019 Arbitration SHALL be round-robin: grant the first eligible port searching upward from rr_ptr, wrapping from port_count-1 to 0.
REQ-020 On grant of port k, the module SHALL latch k, wr[k], address slice k and datain slice k, and set rr_ptr to (k+1) mod port_count.
REQ-021 mem_addr and mem_wdata SHALL be driven from the latched request registers and hold their value outside ACCESS.
REQ-022 mem_wren SHALL equal the latched write flag during ACCESS and be 0 in every other state.
REQ-023 In CAPTURE, for a read, dataout slice k SHALL be loaded with mem_rdata at the end of the cycle; other slices and all slices on writes SHALL hold.
REQ-024 done[k] SHALL be a registered pulse high for exactly the one cycle after CAPTURE (the following IDLE cycle); all other done bits SHALL be 0.
REQ-025 Latency SHALL be fixed: req sampled in IDLE at cycle n, ACCESS at n+1, CAPTURE at n+2, done and dataout valid at n+3; maximum throughput is one access per 3 cycles.
REQ-026 When no port is eligible, the module SHALL stay in IDLE with rr_ptr unchanged.
REQ-027 Simultaneous requests from all ports SHALL be served in rotation, with no port waiting more than port_count grants.
REQ-028 Changes to wr, address or datain after grant SHALL NOT affect the access in flight.
REQ-029 Addresses SHALL pass through unchecked; wrap-around is the RAM's concern.

Reset
REQ-030 On reset, state SHALL be IDLE, rr_ptr 0, and done, busy, mem_wren, mem_addr, mem_wdata and all dataout slices SHALL be 0 from the next cycle.
REQ-031 Reset asserted during ACCESS or CAPTURE SHALL abort the access: mem_wren 0 and no done pulse afterward; the requester re-arbitrates after reset.

Verification
REQ-032 Single read: mem preloaded addr 0x010=0x0AB; req[0]=1, wr=0, addr0=0x010 -> mem_addr=0x010 at n+1, done[0] and dataout[11:0]=0x0AB at n+3.
REQ-033 Single write: req[1]=1, wr=1, addr1=0x020, data1=0x5A5 -> mem_wren=1 only at n+1 with mem_addr=0x020, mem_wdata=0x5A5; done[1] at n+3; dataout unchanged.
REQ-034 Contention: req=2'b11 from reset -> port 0 done at cycle 3, port 1 done at cycle 6; holding both high thereafter -> grants alternate 0,1,0,1.
REQ-035 Done masking: core holds req[0] through the done cycle -> that cycle is not a new grant; next IDLE grants port 0 only if req still high.
REQ-036 Reset mid-write: reset during ACCESS of a write to 0x030 -> mem_wren 0 next cycle, no done pulse, all outputs 0, busy 0.
REQ-037 Input change after grant: address0 changed from 0x040 to 0x041 at n+1 -> mem_addr remains 0x040 for the access.
